// File: rtl/div_pkg.sv
// Shared widths, state codes and handshake values for the multi-cycle divider.
// Small helpers for operand magnitude and result sign correction.
package div_pkg;

  localparam int RegBusW       = 32;
  localparam int DoubleRegBusW = 64;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  function automatic logic [RegBusW-1:0] abs_sel(input logic sgn, input logic [RegBusW-1:0] v);
    return (sgn && v[RegBusW-1]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [RegBusW-1:0] cond_neg(input logic neg, input logic [RegBusW-1:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_if.sv
// EX <-> divider handshake: operands and start/annul in, {rem, quot} and ready out.
interface div_if;
  import div_pkg::*;

  logic                     signed_div_i;
  logic [RegBusW-1:0]       opdata1_i;
  logic [RegBusW-1:0]       opdata2_i;
  logic                     start_i;
  logic                     annul_i;
  logic [DoubleRegBusW-1:0] result_o;
  logic                     ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div.sv
// Radix-2 restoring divider, one quotient bit per clock, signed or unsigned.
// result_o = {remainder, quotient}; registered outputs only.
module div
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  div_state_e               state_q, state_d;
  logic [4:0]               cnt_q, cnt_d;
  logic [64:0]              work_q, work_d;
  logic [RegBusW-1:0]       divisor_q, divisor_d;
  logic                     neg_quot_q, neg_quot_d;
  logic                     neg_rem_q, neg_rem_d;
  logic [DoubleRegBusW-1:0] result_q, result_d;
  logic                     ready_q, ready_d;

  logic [65:0] shifted;
  logic [33:0] diff;
  logic [64:0] stepped;

  // One extra top bit lets the borrow of the 33-bit trial subtract show as diff[33].
  always_comb begin
    shifted = {work_q, 1'b0};
    diff    = shifted[65:32] - {2'b00, divisor_q};
    stepped = diff[33] ? shifted[64:0] : {diff[32:0], shifted[31:1], 1'b1};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        if (bus.start_i == DivStart && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d    = DivOn;
            divisor_d  = abs_sel(bus.signed_div_i, bus.opdata2_i);
            work_d     = {33'd0, abs_sel(bus.signed_div_i, bus.opdata1_i)};
            neg_quot_d = bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
            neg_rem_d  = bus.signed_div_i & bus.opdata1_i[31];
            cnt_d      = '0;
          end
        end
      end
      DivByZero: begin
        state_d  = DivEnd;
        result_d = '0;
        ready_d  = DivResultReady;
      end
      DivOn: begin
        if (bus.annul_i) begin
          state_d  = DivFree;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else begin
          work_d = stepped;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = DivEnd;
            ready_d  = DivResultReady;
            result_d = {cond_neg(neg_rem_q, stepped[63:32]),
                        cond_neg(neg_quot_q, stepped[31:0])};
          end
        end
      end
      DivEnd: begin
        if (bus.start_i == DivStop) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Directed bench for div: latency, signed/unsigned results, divide-by-zero,
// annul and asynchronous reset behaviour against hand-computed values.
module tb_div;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  div_if u_if ();

  div u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Counts step edges after E0 until ready is seen; 99 means it never rose.
  task automatic wait_ready(output int lat);
    lat = 99;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (u_if.ready_o === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
    int lat;
    @(negedge clk);
    u_if.signed_div_i = sgn;
    u_if.opdata1_i    = a;
    u_if.opdata2_i    = b;
    u_if.start_i      = 1'b1;
    @(posedge clk); #1;
    u_if.opdata1_i = ~a;
    u_if.opdata2_i = b ^ 32'h5A5A0000;
    wait_ready(lat);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, u_if.result_o, exp_res);
    @(posedge clk); #1;
    check({tag, " hold ready"}, {63'd0, u_if.ready_o}, 64'd1);
    check({tag, " hold result"}, u_if.result_o, exp_res);
    @(negedge clk);
    u_if.start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, " drop ready"}, {63'd0, u_if.ready_o}, 64'd0);
    check({tag, " drop result"}, u_if.result_o, 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    rst               = 1'b0;
    u_if.signed_div_i = 1'b0;
    u_if.opdata1_i    = '0;
    u_if.opdata2_i    = '0;
    u_if.start_i      = 1'b0;
    u_if.annul_i      = 1'b0;
    #12;
    check("reset ready", {63'd0, u_if.ready_o}, 64'd0);
    check("reset result", u_if.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    do_div("u 100/7",        1'b0, 32'd100,        32'd7,          32, 64'h00000002_0000000E);
    do_div("s -7/2",         1'b1, 32'hFFFFFFF9,   32'd2,          32, 64'hFFFFFFFF_FFFFFFFD);
    do_div("s 7/-2",         1'b1, 32'd7,          32'hFFFFFFFE,   32, 64'h00000001_FFFFFFFD);
    do_div("u FFFFFFF9/2",   1'b0, 32'hFFFFFFF9,   32'd2,          32, 64'h00000001_7FFFFFFC);
    do_div("s -100/-7",      1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32, 64'hFFFFFFFE_0000000E);
    do_div("u FFFFFFFF/1",   1'b0, 32'hFFFFFFFF,   32'd1,          32, 64'h00000000_FFFFFFFF);
    do_div("s min/-1",       1'b1, 32'h80000000,   32'hFFFFFFFF,   32, 64'h00000000_80000000);
    do_div("u 1234/0",       1'b0, 32'd1234,       32'd0,          1,  64'd0);
    do_div("s -5/0",         1'b1, 32'hFFFFFFFB,   32'd0,          1,  64'd0);

    // Annul sampled at step edge E10; EX drops start on the same flush.
    @(negedge clk);
    u_if.signed_div_i = 1'b0;
    u_if.opdata1_i    = 32'd100;
    u_if.opdata2_i    = 32'd7;
    u_if.start_i      = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    u_if.annul_i = 1'b1;
    u_if.start_i = 1'b0;
    @(posedge clk); #1;
    check("annul ready", {63'd0, u_if.ready_o}, 64'd0);
    check("annul result", u_if.result_o, 64'd0);
    @(negedge clk);
    u_if.annul_i = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (u_if.ready_o !== 1'b0) seen++;
    end
    check("annul stays idle", 64'(seen), 64'd0);
    do_div("u 9/3 after annul", 1'b0, 32'd9, 32'd3, 32, 64'h00000000_00000003);

    // Reset while the result is held clears outputs without a clock edge.
    @(negedge clk);
    u_if.signed_div_i = 1'b0;
    u_if.opdata1_i    = 32'd100;
    u_if.opdata2_i    = 32'd7;
    u_if.start_i      = 1'b1;
    @(posedge clk);
    wait_ready(lat);
    check("pre-reset latency", 64'(lat), 64'd32);
    #2;
    rst = 1'b0;
    #1;
    check("async reset end ready", {63'd0, u_if.ready_o}, 64'd0);
    check("async reset end result", u_if.result_o, 64'd0);
    u_if.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Reset mid-division, then a fresh division with start still high.
    @(negedge clk);
    u_if.opdata1_i = 32'd1000;
    u_if.opdata2_i = 32'd33;
    u_if.start_i   = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async reset mid ready", {63'd0, u_if.ready_o}, 64'd0);
    check("async reset mid result", u_if.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    wait_ready(lat);
    check("post-reset latency", 64'(lat), 64'd32);
    check("post-reset result", u_if.result_o, 64'h0000000A_0000001E);
    @(negedge clk);
    u_if.start_i = 1'b0;
    @(posedge clk); #1;
    check("post-reset drop ready", {63'd0, u_if.ready_o}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
